// File: rtl/ldl_p2ram_rd_stream.sv
// Burst read engine for a registered-read dual-port RAM.
// Each command reads a run of words from the RAM, wrapping past the end. The words come out as
// a valid/ready stream, with a 2-entry buffer in front of the output.
module ldl_p2ram_rd_stream #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 10,
   parameter int unsigned AW    = $clog2(DEPTH),
   parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [AW-1:0] cmd_addr,
   input  logic [LW-1:0] cmd_len,
   output logic          ram_re,
   output logic [AW-1:0] ram_ra,
   input  logic [DW-1:0] ram_dout,
   input  logic          ram_rv,
   output logic          o_valid,
   input  logic          o_ready,
   output logic [DW-1:0] o_data,
   output logic          o_last,
   output logic          o_err,
   output logic          busy,
   output logic          err_flag
);

   typedef enum logic {StIdle, StBurst} state_e;

   localparam int unsigned EW = DW + 2;

   state_e        state_q, state_d;
   logic [AW-1:0] ra_q, ra_d;
   logic [LW-1:0] rem_q, rem_d;
   logic          inflight_q, inflight_last_q, inflight_last_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [EW-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
   logic          err_flag_q, err_flag_d;

   logic          accept, pop, push, credit_ok, wr_slot;
   logic [2:0]    occ;
   logic [EW-1:0] push_ent;

   assign pop      = (cnt_q != 2'd0) && o_ready;
   assign push     = inflight_q;
   assign push_ent = {ram_dout, inflight_last_q, ~ram_rv};
   // Occupancy counts the word in flight, so the buffer can always absorb the return.
   assign occ       = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign credit_ok = occ < 3'd2;
   assign accept    = cmd_valid && (state_q == StIdle);
   assign wr_slot   = (cnt_q == 2'd2) || ((cnt_q == 2'd1) && !pop);

   assign cmd_ready = (state_q == StIdle);
   assign ram_re    = (state_q == StBurst) && credit_ok;
   assign ram_ra    = ra_q;
   assign o_valid   = (cnt_q != 2'd0);
   assign o_data    = ent0_q[EW-1:2];
   assign o_last    = ent0_q[1];
   assign o_err     = ent0_q[0];
   assign busy      = (state_q == StBurst) || inflight_q || (cnt_q != 2'd0);
   assign err_flag  = err_flag_q;

   always_comb begin
      state_d         = state_q;
      ra_d            = ra_q;
      rem_d           = rem_q;
      inflight_last_d = inflight_last_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               ra_d  = cmd_addr;
               rem_d = cmd_len;
               if (cmd_len != '0) state_d = StBurst;
            end
         end
         StBurst: begin
            if (ram_re) begin
               ra_d            = (ra_q == AW'(DEPTH - 1)) ? '0 : ra_q + AW'(1);
               rem_d           = rem_q - LW'(1);
               inflight_last_d = (rem_q == LW'(1));
               if (rem_q == LW'(1)) state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ent0_d     = ent0_q;
      ent1_d     = ent1_q;
      cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
      err_flag_d = err_flag_q | (push & ~ram_rv);
      if (pop) ent0_d = ent1_q;
      if (push) begin
         if (wr_slot) ent1_d = push_ent;
         else         ent0_d = push_ent;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= StIdle;
         ra_q            <= '0;
         rem_q           <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         cnt_q           <= 2'd0;
         ent0_q          <= '0;
         ent1_q          <= '0;
         err_flag_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         ra_q            <= ra_d;
         rem_q           <= rem_d;
         inflight_q      <= ram_re;
         inflight_last_q <= inflight_last_d;
         cnt_q           <= cnt_d;
         ent0_q          <= ent0_d;
         ent1_q          <= ent1_d;
         err_flag_q      <= err_flag_d;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (cnt_q <= 2'd2);
         assert (!(push && !pop && (cnt_q == 2'd2)));
      end
   end
`endif

endmodule

// File: tb/tb_ldl_p2ram_rd_stream.sv
// Randomized and directed bench for ldl_p2ram_rd_stream.
// The reference model expands each accepted command into its expected beats and addresses.
module tb_ldl_p2ram_rd_stream;

   localparam int DW    = 8;
   localparam int DEPTH = 10;
   localparam int AW    = 4;
   localparam int LW    = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic          err;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [AW-1:0] cmd_addr = '0;
   logic [LW-1:0] cmd_len = '0;
   logic          ram_re;
   logic [AW-1:0] ram_ra;
   logic [DW-1:0] ram_dout = '0;
   logic          ram_rv = 1'b1;
   logic          o_valid;
   logic          o_ready = 1'b1;
   logic [DW-1:0] o_data;
   logic          o_last;
   logic          o_err;
   logic          busy;
   logic          err_flag;

   logic [DW-1:0] mem [0:15];
   logic          ram_we;
   bit            coll_en = 1'b0;
   logic [AW-1:0] coll_addr = '0;

   beat_t         exp_q[$];
   logic [AW-1:0] addr_q[$];
   int            n_checks = 0;
   int            n_fail = 0;
   int            issued = 0;
   int            popped = 0;
   bit            prev_stall = 1'b0;
   beat_t         prev_beat;
   bit            exp_err_flag = 1'b0;
   int            ready_mode = 0;
   int            ready_phase = 0;

   ldl_p2ram_rd_stream #(
      .DW   (DW),
      .DEPTH(DEPTH),
      .AW   (AW),
      .LW   (LW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_addr (cmd_addr),
      .cmd_len  (cmd_len),
      .ram_re   (ram_re),
      .ram_ra   (ram_ra),
      .ram_dout (ram_dout),
      .ram_rv   (ram_rv),
      .o_valid  (o_valid),
      .o_ready  (o_ready),
      .o_data   (o_data),
      .o_last   (o_last),
      .o_err    (o_err),
      .busy     (busy),
      .err_flag (err_flag)
   );

   always #5 clk = ~clk;

   // Colliding write rewrites the same value, so only rv is affected.
   assign ram_we = coll_en && ram_re && (ram_ra == coll_addr);

   always @(posedge clk) begin
      if (ram_re) begin
         ram_dout <= mem[ram_ra];
         ram_rv   <= !ram_we;
      end
   end

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: o_ready = 1'b1;
         1: o_ready = 1'($urandom_range(0, 1));
         2: begin
            o_ready = (ready_phase % 3 == 0);
            ready_phase++;
         end
         default: o_ready = 1'b0;
      endcase
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         int    occ;
         beat_t b;
         occ = issued - popped;
         check_eq("occ_le2", 32'(occ <= 2), 1);
         if (prev_stall) begin
            check_eq("hold_valid", 32'(o_valid), 1);
            check_eq("hold_beat", 32'({o_data, o_last, o_err}), 32'(prev_beat));
         end
         if (o_valid && o_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("extra_beat", 1, 0);
            end else begin
               b = exp_q.pop_front();
               check_eq("beat_data", 32'(o_data), 32'(b.data));
               check_eq("beat_last", 32'(o_last), 32'(b.last));
               check_eq("beat_err", 32'(o_err), 32'(b.err));
            end
            popped++;
         end
         if (ram_re) begin
            check_eq("credit", 32'((occ - int'(o_valid && o_ready)) < 2), 1);
            if (addr_q.size() == 0) check_eq("extra_issue", 1, 0);
            else                    check_eq("ram_ra", 32'(ram_ra), 32'(addr_q.pop_front()));
            issued++;
         end
         prev_stall = o_valid && !o_ready;
         prev_beat  = {o_data, o_last, o_err};
      end
   end

   task automatic send_cmd(input int addr, input int len);
      int    n;
      int    a;
      beat_t b;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_addr  = AW'(addr);
      cmd_len   = LW'(len);
      n = 0;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         check_eq("cmd_timeout", 0, 1);
         cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      for (int i = 0; i < len; i++) begin
         a      = (addr + i) % DEPTH;
         b.data = mem[a];
         b.last = (i == len - 1);
         b.err  = coll_en && (AW'(a) == coll_addr);
         exp_err_flag |= b.err;
         exp_q.push_back(b);
         addr_q.push_back(AW'(a));
      end
      #1 cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || busy) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check_eq("drain_left", 32'(exp_q.size()), 0);
      check_eq("drain_busy", 32'(busy), 0);
   endtask

   task automatic apply_reset(input int cycles);
      @(negedge clk);
      rst = 1'b1;
      repeat (cycles) @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      addr_q.delete();
      issued       = 0;
      popped       = 0;
      prev_stall   = 1'b0;
      exp_err_flag = 1'b0;
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_cmd_ready", 32'(cmd_ready), 1);
      check_eq("rst_ram_re", 32'(ram_re), 0);
      check_eq("rst_ram_ra", 32'(ram_ra), 0);
      check_eq("rst_o_valid", 32'(o_valid), 0);
      check_eq("rst_o_data", 32'(o_data), 0);
      check_eq("rst_o_last", 32'(o_last), 0);
      check_eq("rst_o_err", 32'(o_err), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_err_flag", 32'(err_flag), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = DW'(i);
      apply_reset(3);
      @(negedge clk);
      check_reset_outputs();

      // Full-throughput latency: accept at t, beats at t+3..t+6, cmd_ready back at t+5.
      send_cmd(2, 4);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         check_eq("t1_valid", 32'(o_valid), 32'(k >= 3 && k <= 6));
         check_eq("t1_cmd_ready", 32'(cmd_ready), 32'(k >= 5));
         check_eq("t1_ram_re", 32'(ram_re), 32'(k <= 4));
         if (k == 6) check_eq("t1_last", 32'(o_last), 1);
      end
      drain();

      send_cmd(8, 5);
      drain();

      ready_mode  = 2;
      ready_phase = 0;
      send_cmd(1, 6);
      drain();
      ready_mode = 0;

      coll_en   = 1'b1;
      coll_addr = AW'(3);
      send_cmd(1, 5);
      drain();
      coll_en = 1'b0;
      check_eq("err_flag_set", 32'(err_flag), 32'(exp_err_flag));
      send_cmd(0, 2);
      drain();
      check_eq("err_flag_sticky", 32'(err_flag), 1);

      send_cmd(0, 3);
      send_cmd(7, 2);
      send_cmd(5, 0);
      drain();
      send_cmd(4, 0);
      @(negedge clk);
      check_eq("len0_busy", 32'(busy), 0);
      check_eq("len0_ready", 32'(cmd_ready), 1);

      // Reset mid-burst with the sink stalled and the buffer full.
      ready_mode = 3;
      send_cmd(0, 8);
      repeat (5) @(negedge clk);
      check_eq("pre_rst_busy", 32'(busy), 1);
      apply_reset(1);
      ready_mode = 0;
      @(negedge clk);
      check_reset_outputs();
      @(negedge clk);
      check_eq("post_rst_valid", 32'(o_valid), 0);
      check_eq("post_rst_busy", 32'(busy), 0);
      send_cmd(6, 1);
      drain();

      ready_mode = 1;
      for (int r = 0; r < 8; r++) begin
         drain();
         for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
         for (int j = 0; j < 4; j++) send_cmd($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH));
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
